dsp_data_mem_ctrl: RTL and testbench

//  Parametrised data memory for the DSP core load/store unit. Generalises the

---
 rtl/dsp_mem_pkg.sv | 36 +++
 rtl/dsp_mem_load_ext.sv | 36 +++
 rtl/dsp_data_mem_ctrl.sv | 133 +++++++++++++
 tb/tb_dsp_data_mem_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mem_pkg.sv
// Shared types for the DSP data memory: access sizes, FSM states,
// latched load control and the byte-enable decode.
package dsp_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] size;
    logic [1:0] off;
    logic       sgn;
  } ld_ctl_t;

  function automatic logic [3:0] be_from_size(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr;
      SZ_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dsp_mem_load_ext.sv
// Lane extract and sign/zero extension of a 32-bit word for
// byte, halfword and word loads.
module dsp_mem_load_ext (
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  output logic [31:0] data
);
  import dsp_mem_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    unique case (off)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
    endcase
  end

  assign h = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (size)
      SZ_BYTE: data = {{24{sgn & b[7]}}, b};
      SZ_HALF: data = {{16{sgn & h[15]}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dsp_data_mem_ctrl.sv
// LSU data memory: byte/half/word access, valid/ready request and
// response channels, configurable read latency, error reporting.
module dsp_data_mem_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 1,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  import dsp_mem_pkg::*;

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_W - 2;

  state_t      state;
  logic [2:0]  cnt;
  logic        err_q;
  logic        ld_q;
  ld_ctl_t     ctl_q;
  logic [31:0] word_q;
  logic [31:0] ext;

  logic [31:0] mem [0:DEPTH-1];

  logic [WW-1:0] widx;
  logic [IW-1:0] idx;
  logic          acc;
  logic          err;
  logic [3:0]    be;
  logic [31:0]   wlane;

  assign widx = req_addr[ADDR_W-1:2];
  assign idx  = req_addr[IW+1:2];

  assign req_ready = (state == IDLE);
  assign acc       = req_valid & req_ready;

  // Out-of-range covers the gap above DEPTH when it is not a power of 2.
  assign err = (req_size == SZ_ILL)
             | ((req_size == SZ_HALF) & req_addr[0])
             | ((req_size == SZ_WORD) & (|req_addr[1:0]))
             | (widx >= WW'(DEPTH));

  assign be = be_from_size(req_size, req_addr[1:0]);

  always_comb begin
    wlane = req_wdata;
    case (req_size)
      SZ_BYTE: wlane = {4{req_wdata[7:0]}};
      SZ_HALF: wlane = {2{req_wdata[15:0]}};
      default: wlane = req_wdata;
    endcase
  end

  // Read-first: word_q captures the old word even on a store.
  always_ff @(posedge clk) begin
    if (acc) begin
      word_q <= mem[idx];
      if (req_we & ~err) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      ld_q  <= 1'b0;
      ctl_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            err_q      <= err;
            ld_q       <= ~req_we & ~err;
            ctl_q.size <= req_size;
            ctl_q.off  <= req_addr[1:0];
            ctl_q.sgn  <= req_signed;
            if (RD_LAT == 1) begin
              cnt   <= '0;
              state <= RESP;
            end else begin
              cnt   <= 3'd1;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'(RD_LAT - 1)) begin
            cnt   <= '0;
            state <= RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dsp_mem_load_ext u_ext (
    .word (word_q),
    .size (ctl_q.size),
    .off  (ctl_q.off),
    .sgn  (ctl_q.sgn),
    .data (ext)
  );

  assign rsp_valid = (state == RESP);
  assign rsp_rdata = ld_q ? ext : 32'h0;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dsp_data_mem_ctrl.sv
// Scoreboard bench for dsp_data_mem_ctrl with RD_LAT=3, DEPTH=64
// against a byte-array reference model.
module tb_dsp_data_mem_ctrl;

  localparam int RD_LAT = 3;
  localparam int DEPTH  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  ref_b [0:DEPTH*4-1];
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  dsp_data_mem_ctrl #(
    .ADDR_W (32),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model(input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [32:0] e);
    logic er;
    logic [7:0] b;
    logic [15:0] h;
    int i;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0])
      || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'(DEPTH*4));
    i = int'(a[7:0]);
    e = '0;
    if (er) begin
      e = {1'b1, 32'h0};
    end else if (we) begin
      ref_b[i] = wd[7:0];
      if (sz != 2'd0) ref_b[i+1] = wd[15:8];
      if (sz == 2'd2) begin
        ref_b[i+2] = wd[23:16];
        ref_b[i+3] = wd[31:24];
      end
    end else begin
      b = ref_b[i];
      if (sz == 2'd0) begin
        e[31:0] = sg ? {{24{b[7]}}, b} : {24'h0, b};
      end else if (sz == 2'd1) begin
        h = {ref_b[i+1], ref_b[i]};
        e[31:0] = sg ? {{16{h[15]}}, h} : {16'h0, h};
      end else begin
        e[31:0] = {ref_b[i+3], ref_b[i+2], ref_b[i+1], ref_b[i]};
      end
    end
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int stall,
                        input bit rnd, input bit hold_chk);
    logic [32:0] e;
    logic [32:0] got;
    int lat;
    model(we, sz, sg, a, wd, e);
    sb.push_back(e);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_size   = 2'(~sz);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid && rnd) rsp_ready = 1'($urandom_range(0, 1));
    end while (!rsp_valid && lat < 20);
    chk("latency", 64'(lat), 64'(RD_LAT));
    if (!rsp_valid) begin
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      if (hold_chk) begin
        chk("hold_valid", 64'(rsp_valid), 64'd1);
        chk("hold_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        chk("hold_req_ready", 64'(req_ready), 64'd0);
      end
    end
    rsp_ready = 1'b1;
    got = sb.pop_front();
    chk("rdata", 64'(rsp_rdata), 64'(got[31:0]));
    chk("err", 64'(rsp_err), 64'(got[32]));
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] e;
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;

    for (int w = 0; w < DEPTH; w++)
      run_op(1'b1, 2'd2, 1'b0, 32'(w*4), $urandom, 0, 0, 0);

    run_op(1'b1, 2'd2, 1'b0, 32'h04, 32'hDEADBEEF, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0, 0, 0);

    run_op(1'b1, 2'd2, 1'b0, 32'h08, 32'h0, 0, 0, 0);
    run_op(1'b1, 2'd0, 1'b0, 32'h09, 32'h000000A5, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 0, 0, 0);
    run_op(1'b1, 2'd1, 1'b0, 32'h0E, 32'h00008123, 0, 0, 0);
    run_op(1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, 0, 0, 0);

    run_op(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 0, 0, 0);
    run_op(1'b1, 2'd2, 1'b0, 32'h102, 32'h11223344, 0, 0, 0);
    run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'h55667788, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, 0, 0);
    run_op(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 0, 0, 0);

    run_op(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 5, 0, 1);

    // Store interrupted by reset mid-WAIT: response dropped, data kept.
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("postrst_req_ready", 64'(req_ready), 64'd1);
    run_op(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(256, 511))
                                         : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      run_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 2), 1, 0);
    end

    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
